// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply,
// radix-2 restoring divide, valid/ready request and response.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] data1,
  input  logic [XLEN-1:0] data2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result
);
  localparam int CW = $clog2(XLEN + 1);
  localparam logic [XLEN-1:0] MINV =
    {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] ONES = '1;

  typedef enum logic [1:0] {
    IDLE, CALC, DONE
  } state_e;

  state_e            state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic              neg_q, neg_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [XLEN-1:0]   a_q, a_d;
  logic [2*XLEN-1:0] prod_q, prod_d;
  logic [XLEN:0]     rem_q, rem_d;
  logic [XLEN-1:0]   res_q, res_d;

  logic            sgn1, sgn2, s1, s2;
  logic            div_zero, div_ovf;
  logic [XLEN-1:0] mag1, mag2;

  assign sgn1 = op[2] ? ~op[0] : (op != 3'b011);
  assign sgn2 = op[2] ? ~op[0] : (op[2:1] == 2'b00);
  assign s1   = sgn1 & data1[XLEN-1];
  assign s2   = sgn2 & data2[XLEN-1];
  assign mag1 = s1 ? -data1 : data1;
  assign mag2 = s2 ? -data2 : data2;

  assign div_zero = op[2] && (data2 == '0);
  assign div_ovf  = op[2] && !op[0] &&
                    (data1 == MINV) && (data2 == ONES);

  logic [XLEN:0]     macc;
  logic [XLEN:0]     shl, rem_n;
  logic [XLEN+1:0]   diff;
  logic              borrow;
  logic [2*XLEN-1:0] mul_n, div_n, it_prod, p_s;
  logic [XLEN-1:0]   d_raw, d_s, fin;

  // prod_q low half: multiplier (mul) or dividend/quotient (div)
  assign macc  = {1'b0, prod_q[2*XLEN-1:XLEN]} +
                 (prod_q[0] ? {1'b0, a_q} : '0);
  assign mul_n = {macc, prod_q[XLEN-1:1]};

  assign shl    = {rem_q[XLEN-1:0], prod_q[XLEN-1]};
  assign diff   = {rem_q, prod_q[XLEN-1]} - {2'b00, a_q};
  assign borrow = diff[XLEN+1];
  assign rem_n  = borrow ? shl : diff[XLEN:0];
  assign div_n  = {prod_q[2*XLEN-1:XLEN],
                   prod_q[XLEN-2:0], ~borrow};

  assign it_prod = op_q[2] ? div_n : mul_n;
  assign p_s     = neg_q ? -it_prod : it_prod;
  assign d_raw   = op_q[1] ? rem_n[XLEN-1:0]
                           : it_prod[XLEN-1:0];
  assign d_s     = neg_q ? -d_raw : d_raw;
  assign fin     = op_q[2] ? d_s :
                   (op_q[1:0] == 2'b00) ? p_s[XLEN-1:0]
                                        : p_s[2*XLEN-1:XLEN];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= '0;
      neg_q   <= 1'b0;
      cnt_q   <= '0;
      a_q     <= '0;
      prod_q  <= '0;
      rem_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      neg_q   <= neg_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      prod_q  <= prod_d;
      rem_q   <= rem_d;
      res_q   <= res_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    neg_d   = neg_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    prod_d  = prod_q;
    rem_d   = rem_q;
    res_d   = res_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          op_d   = op;
          neg_d  = (op[2] && op[1]) ? s1 : (s1 ^ s2);
          cnt_d  = CW'(XLEN);
          a_d    = op[2] ? mag2 : mag1;
          prod_d = {{XLEN{1'b0}}, op[2] ? mag1 : mag2};
          rem_d  = '0;
          if (div_zero) begin
            res_d   = op[1] ? data1 : ONES;
            state_d = DONE;
          end else if (div_ovf) begin
            res_d   = op[1] ? '0 : data1;
            state_d = DONE;
          end else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        cnt_d  = cnt_q - CW'(1);
        prod_d = it_prod;
        if (op_q[2]) rem_d = rem_n;
        // last iteration: sign-correct the fresh value
        if (cnt_q == CW'(1)) begin
          res_d   = fin;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = res_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit (XLEN=32): vector table,
// random ops against a reference model, reset and backpressure.
module tb_muldiv_unit;
  localparam logic [31:0] MINV = 32'h8000_0000;
  localparam logic [31:0] ONES = 32'hFFFF_FFFF;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  op;
  logic [31:0] data1;
  logic [31:0] data2;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;

  muldiv_unit #(.XLEN(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .data1     (data1),
    .data2     (data2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  int checks = 0;
  int failures = 0;
  logic [31:0] sbq[$];
  int          latq[$];

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] model(
    input logic [2:0] o, input logic [31:0] a,
    input logic [31:0] b);
    logic [63:0] p;
    longint sa, sb, ub;
    logic ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ub  = longint'({32'b0, b});
    ovf = (a == MINV) && (b == ONES);
    case (o)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin
        p = {32'b0, a} * {32'b0, b};
        return p[63:32];
      end
      3'd4: begin
        if (b == 0) return ONES;
        if (ovf) return a;
        return 32'($signed(a) / $signed(b));
      end
      3'd5: return (b == 0) ? ONES : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (ovf) return 32'd0;
        return 32'($signed(a) % $signed(b));
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int model_lat(
    input logic [2:0] o, input logic [31:0] a,
    input logic [31:0] b);
    if (o[2] && (b == 0)) return 1;
    if (o[2] && !o[0] && a == MINV && b == ONES) return 1;
    return 33;
  endfunction

  task automatic issue(input logic [2:0] o,
                       input logic [31:0] a,
                       input logic [31:0] b,
                       input logic [31:0] e,
                       input int l);
    int w;
    w = 0;
    @(negedge clk);
    while (!in_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    chk("issue_ready", in_ready, 1);
    in_valid = 1'b1;
    op       = o;
    data1    = a;
    data2    = b;
    @(posedge clk);
    sbq.push_back(e);
    latq.push_back(l);
  endtask

  task automatic collect(input string nm);
    int n;
    int l;
    logic [31:0] e;
    @(negedge clk);
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_valid"}, out_valid, 1);
    l = (latq.size() != 0) ? latq.pop_front() : -1;
    e = (sbq.size() != 0) ? sbq.pop_front() : 'x;
    chk({nm, "_lat"}, 64'(n), 64'(l));
    chk({nm, "_res"}, result, e);
    if (out_ready) begin
      @(negedge clk);
      chk({nm, "_hs"}, out_valid, 0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[20];
    logic [2:0]  ro;
    logic [31:0] ra, rb;

    vecs[0]  = '{3'd0, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 33};
    vecs[1]  = '{3'd1, MINV, MINV, 32'h40000000, 33};
    vecs[2]  = '{3'd2, ONES, ONES, ONES, 33};
    vecs[3]  = '{3'd3, ONES, ONES, 32'hFFFFFFFE, 33};
    vecs[4]  = '{3'd4, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 33};
    vecs[5]  = '{3'd6, 32'hFFFFFFF9, 32'd2, ONES, 33};
    vecs[6]  = '{3'd5, 32'd100, 32'd7, 32'd14, 33};
    vecs[7]  = '{3'd7, 32'd100, 32'd7, 32'd2, 33};
    vecs[8]  = '{3'd4, 32'd5, 32'd0, ONES, 1};
    vecs[9]  = '{3'd7, 32'd5, 32'd0, 32'd5, 1};
    vecs[10] = '{3'd4, MINV, ONES, MINV, 1};
    vecs[11] = '{3'd6, MINV, ONES, 32'd0, 1};
    vecs[12] = '{3'd5, 32'd5, 32'd0, ONES, 1};
    vecs[13] = '{3'd6, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, 1};
    vecs[14] = '{3'd0, MINV, ONES, MINV, 33};
    vecs[15] = '{3'd4, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 33};
    vecs[16] = '{3'd6, 32'd7, 32'hFFFFFFFE, 32'd1, 33};
    vecs[17] = '{3'd3, 32'd0, 32'd0, 32'd0, 33};
    vecs[18] = '{3'd1, ONES, ONES, 32'd0, 33};
    vecs[19] = '{3'd5, ONES, 32'd1, ONES, 33};

    rst       = 1'b0;
    in_valid  = 1'b0;
    op        = 3'd0;
    data1     = '0;
    data2     = '0;
    out_ready = 1'b1;
    #1 rst = 1'b1;
    #2;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", result, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("post_rst_in_ready", in_ready, 1);
    chk("post_rst_out_valid", out_valid, 0);

    for (int i = 0; i < 20; i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b,
            vecs[i].exp, vecs[i].lat);
      collect($sformatf("vec%0d", i));
    end

    for (int i = 0; i < 24; i++) begin
      ro = 3'($urandom_range(0, 7));
      ra = $urandom;
      case ($urandom_range(0, 4))
        0: rb = 32'd0;
        1: rb = 32'($urandom_range(1, 15));
        2: begin ra = MINV; rb = ONES; end
        default: rb = $urandom;
      endcase
      issue(ro, ra, rb, model(ro, ra, rb),
            model_lat(ro, ra, rb));
      collect($sformatf("rnd%0d", i));
    end

    // backpressure with a competing request held on the input
    out_ready = 1'b0;
    issue(3'd0, 32'd3, 32'd5, 32'd15, 33);
    collect("bp");
    in_valid = 1'b1;
    op       = 3'd5;
    data1    = 32'd200;
    data2    = 32'd3;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("bp_res%0d", k), result, 15);
      chk($sformatf("bp_rdy%0d", k), in_ready, 0);
      chk($sformatf("bp_vld%0d", k), out_valid, 1);
      data1 = 32'(300 + k);
    end
    data1     = 32'd100;
    data2     = 32'd7;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("bp_after_rdy", in_ready, 1);
    chk("bp_after_vld", out_valid, 0);
    sbq.push_back(32'd14);
    latq.push_back(33);
    @(posedge clk);
    collect("bp_next");

    // reset while a result is pending
    out_ready = 1'b0;
    issue(3'd0, 32'd2, 32'd3, 32'd6, 33);
    collect("rdone");
    #2 rst = 1'b1;
    #1;
    chk("rdone_vld", out_valid, 0);
    chk("rdone_res", result, 0);
    chk("rdone_rdy", in_ready, 1);
    @(negedge clk);
    rst       = 1'b0;
    out_ready = 1'b1;

    // reset ten cycles into CALC
    issue(3'd3, ONES, ONES, 32'hFFFFFFFE, 33);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    chk("rcalc_busy", in_ready, 0);
    #2 rst = 1'b1;
    #1;
    chk("rcalc_vld", out_valid, 0);
    chk("rcalc_rdy", in_ready, 1);
    sbq.delete();
    latq.delete();
    @(negedge clk);
    rst = 1'b0;
    issue(3'd3, ONES, ONES, 32'hFFFFFFFE, 33);
    collect("rcalc");

    chk("sb_empty", 64'(sbq.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
